// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: micro-sequencer for the 5-bit datapath (bus driver, accumulator, ALU, flag FF).
// It accepts one conditional instruction per valid/ready handshake and steps the datapath
// enables through the bus-load, execute and flag-capture cycles. Retirement is reported
// through done/skipped pulses and a wrapping retire counter.
//
// state | meaning
// IDLE  | waiting for an instruction
// BUS   | immediate driven onto the bus (enableDB)
// EXEC  | ALU result loaded into the accumulator (enableDB, enableR)
// FLAG  | flags captured (enableDB, enableFF)
// DONE  | retire pulse; can accept the next instruction in the same cycle
module alu_seq_ctrl #(
  parameter int DATA_W = 5,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [2+OP_W+DATA_W-1:0] instr,
  input  logic                     flush,
  input  logic                     flag_c,
  input  logic                     flag_ze,
  output logic [OP_W-1:0]          F,
  output logic [DATA_W-1:0]        B,
  output logic                     enableDB,
  output logic                     enableR,
  output logic                     enableFF,
  output logic                     busy,
  output logic                     done,
  output logic                     skipped,
  output logic [CNT_W-1:0]         retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BUS  = 3'd1,
    S_EXEC = 3'd2,
    S_FLAG = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_rdy_en;
  logic [OP_W-1:0]     r_op, w_op_nxt;
  logic [OP_W-1:0]     r_f, w_f_nxt;
  logic [DATA_W-1:0]   r_b, w_b_nxt;
  logic                r_en_db, w_en_db_nxt;
  logic                r_en_r, w_en_r_nxt;
  logic                r_en_ff, w_en_ff_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_skip, w_skip_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

  logic [1:0]          w_cond;
  logic [OP_W-1:0]     w_op_in;
  logic [DATA_W-1:0]   w_imm_in;
  logic                w_cond_ok;
  logic                w_accept;

  assign w_cond   = instr[2+OP_W+DATA_W-1 -: 2];
  assign w_op_in  = instr[OP_W+DATA_W-1 -: OP_W];
  assign w_imm_in = instr[DATA_W-1:0];

  // ready is held low until the first edge after reset so nothing is accepted mid-release
  assign instr_ready = r_rdy_en & ~flush & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_accept    = instr_valid & instr_ready;

  // condition code evaluated on the flags present at the accept edge
  always_comb begin
    w_cond_ok = 1'b1;
    case (w_cond)
      2'b00:   w_cond_ok = 1'b1;
      2'b01:   w_cond_ok = flag_ze;
      2'b10:   w_cond_ok = flag_c;
      default: w_cond_ok = ~flag_ze;
    endcase
  end

  // next state and next registered outputs; F/B hold unless a step drives them
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_f_nxt     = r_f;
    w_b_nxt     = r_b;
    w_en_db_nxt = 1'b0;
    w_en_r_nxt  = 1'b0;
    w_en_ff_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_skip_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;

    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_BUS: begin
          w_state_nxt = S_EXEC;
          w_en_db_nxt = 1'b1;
          w_en_r_nxt  = 1'b1;
          w_busy_nxt  = 1'b1;
          w_f_nxt     = r_op;
        end
        S_EXEC: begin
          w_state_nxt = S_FLAG;
          w_en_db_nxt = 1'b1;
          w_en_ff_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_f_nxt     = r_op;
        end
        S_FLAG: begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
        default: begin
          // IDLE and DONE share the accept path
          if (w_accept) begin
            w_op_nxt = w_op_in;
            if (w_cond_ok) begin
              w_state_nxt = S_BUS;
              w_en_db_nxt = 1'b1;
              w_busy_nxt  = 1'b1;
              w_b_nxt     = w_imm_in;
            end else begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
              w_skip_nxt  = 1'b1;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_rdy_en <= 1'b0;
      r_op     <= '0;
      r_f      <= '0;
      r_b      <= '0;
      r_en_db  <= 1'b0;
      r_en_r   <= 1'b0;
      r_en_ff  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_skip   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
      r_op     <= w_op_nxt;
      r_f      <= w_f_nxt;
      r_b      <= w_b_nxt;
      r_en_db  <= w_en_db_nxt;
      r_en_r   <= w_en_r_nxt;
      r_en_ff  <= w_en_ff_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_skip   <= w_skip_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign F          = r_f;
  assign B          = r_b;
  assign enableDB   = r_en_db;
  assign enableR    = r_en_r;
  assign enableFF   = r_en_ff;
  assign busy       = r_busy;
  assign done       = r_done;
  assign skipped    = r_skip;
  assign retire_cnt = r_cnt;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed per-cycle vector table for alu_seq_ctrl plus hand-written
// sequences for async reset mid-instruction and retire counter wrap.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [9:0]  instr;
  logic        flush;
  logic        flag_c;
  logic        flag_ze;
  logic [2:0]  F;
  logic [4:0]  B;
  logic        enableDB;
  logic        enableR;
  logic        enableFF;
  logic        busy;
  logic        done;
  logic        skipped;
  logic [7:0]  retire_cnt;

  int errors = 0;
  int checks = 0;

  alu_seq_ctrl #(.DATA_W(5), .OP_W(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .flush(flush), .flag_c(flag_c), .flag_ze(flag_ze),
    .F(F), .B(B), .enableDB(enableDB), .enableR(enableR), .enableFF(enableFF),
    .busy(busy), .done(done), .skipped(skipped), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ready, enDB, enR, enFF, busy, done, skipped, F[2:0], B[4:0], cnt[7:0]}
  typedef struct {
    logic        valid;
    logic [9:0]  instr;
    logic        flush;
    logic        c;
    logic        ze;
    logic [22:0] exp;
  } vec_t;

  localparam int NV = 37;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic valid, input logic [1:0] cond, input logic [2:0] op,
                              input logic [4:0] imm, input logic fl, input logic c, input logic ze,
                              input logic rdy, input logic [2:0] en, input logic bsy,
                              input logic dn, input logic sk, input logic [2:0] f,
                              input logic [4:0] b, input logic [7:0] cnt);
    vec_t v;
    v.valid = valid;
    v.instr = {cond, op, imm};
    v.flush = fl;
    v.c     = c;
    v.ze    = ze;
    v.exp   = {rdy, en, bsy, dn, sk, f, b, cnt};
    return v;
  endfunction

  function automatic logic [22:0] act();
    return {instr_ready, enableDB, enableR, enableFF, busy, done, skipped, F, B, retire_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  int cyc;
  int ndone;
  int last_done;
  bit seen;

  initial begin
    //               v   cond   op    imm     fl  c   ze  | rdy  en      bsy dn  sk  F     B       cnt
    tbl[0]  = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b000,1'b0,1'b0,1'b0,3'd0,5'd0, 8'd0);
    tbl[1]  = mk(1'b1,2'd0,3'd2,5'd3, 1'b0,1'b0,1'b0, 1'b1,3'b000,1'b0,1'b0,1'b0,3'd0,5'd0, 8'd0);
    tbl[2]  = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b100,1'b1,1'b0,1'b0,3'd0,5'd3, 8'd0);
    tbl[3]  = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b110,1'b1,1'b0,1'b0,3'd2,5'd3, 8'd0);
    tbl[4]  = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b101,1'b1,1'b0,1'b0,3'd2,5'd3, 8'd0);
    tbl[5]  = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b1,3'b000,1'b0,1'b1,1'b0,3'd2,5'd3, 8'd1);
    tbl[6]  = mk(1'b1,2'd1,3'd3,5'd1, 1'b0,1'b0,1'b0, 1'b1,3'b000,1'b0,1'b0,1'b0,3'd2,5'd3, 8'd1);
    tbl[7]  = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b1,3'b000,1'b0,1'b1,1'b1,3'd2,5'd3, 8'd1);
    tbl[8]  = mk(1'b1,2'd0,3'd1,5'd5, 1'b0,1'b0,1'b0, 1'b1,3'b000,1'b0,1'b0,1'b0,3'd2,5'd3, 8'd1);
    tbl[9]  = mk(1'b1,2'd1,3'd4,5'd7, 1'b0,1'b0,1'b0, 1'b0,3'b100,1'b1,1'b0,1'b0,3'd2,5'd5, 8'd1);
    tbl[10] = mk(1'b1,2'd1,3'd4,5'd7, 1'b0,1'b0,1'b0, 1'b0,3'b110,1'b1,1'b0,1'b0,3'd1,5'd5, 8'd1);
    tbl[11] = mk(1'b1,2'd1,3'd4,5'd7, 1'b0,1'b0,1'b0, 1'b0,3'b101,1'b1,1'b0,1'b0,3'd1,5'd5, 8'd1);
    tbl[12] = mk(1'b1,2'd1,3'd4,5'd7, 1'b0,1'b0,1'b1, 1'b1,3'b000,1'b0,1'b1,1'b0,3'd1,5'd5, 8'd2);
    tbl[13] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b1, 1'b0,3'b100,1'b1,1'b0,1'b0,3'd1,5'd7, 8'd2);
    tbl[14] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b1, 1'b0,3'b110,1'b1,1'b0,1'b0,3'd4,5'd7, 8'd2);
    tbl[15] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b101,1'b1,1'b0,1'b0,3'd4,5'd7, 8'd2);
    tbl[16] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b1,3'b000,1'b0,1'b1,1'b0,3'd4,5'd7, 8'd3);
    tbl[17] = mk(1'b1,2'd0,3'd5,5'd10,1'b0,1'b0,1'b0, 1'b1,3'b000,1'b0,1'b0,1'b0,3'd4,5'd7, 8'd3);
    tbl[18] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b100,1'b1,1'b0,1'b0,3'd4,5'd10,8'd3);
    tbl[19] = mk(1'b0,2'd0,3'd0,5'd0, 1'b1,1'b0,1'b0, 1'b0,3'b110,1'b1,1'b0,1'b0,3'd5,5'd10,8'd3);
    tbl[20] = mk(1'b1,2'd0,3'd6,5'd1, 1'b0,1'b0,1'b0, 1'b1,3'b000,1'b0,1'b0,1'b0,3'd5,5'd10,8'd3);
    tbl[21] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b100,1'b1,1'b0,1'b0,3'd5,5'd1, 8'd3);
    tbl[22] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b110,1'b1,1'b0,1'b0,3'd6,5'd1, 8'd3);
    tbl[23] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b101,1'b1,1'b0,1'b0,3'd6,5'd1, 8'd3);
    tbl[24] = mk(1'b1,2'd0,3'd6,5'd1, 1'b1,1'b0,1'b0, 1'b0,3'b000,1'b0,1'b1,1'b0,3'd6,5'd1, 8'd4);
    tbl[25] = mk(1'b1,2'd2,3'd7,5'd31,1'b0,1'b0,1'b0, 1'b1,3'b000,1'b0,1'b0,1'b0,3'd6,5'd1, 8'd4);
    tbl[26] = mk(1'b1,2'd2,3'd7,5'd31,1'b0,1'b1,1'b0, 1'b1,3'b000,1'b0,1'b1,1'b1,3'd6,5'd1, 8'd4);
    tbl[27] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b100,1'b1,1'b0,1'b0,3'd6,5'd31,8'd4);
    tbl[28] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b110,1'b1,1'b0,1'b0,3'd7,5'd31,8'd4);
    tbl[29] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b101,1'b1,1'b0,1'b0,3'd7,5'd31,8'd4);
    tbl[30] = mk(1'b1,2'd3,3'd0,5'd2, 1'b0,1'b0,1'b1, 1'b1,3'b000,1'b0,1'b1,1'b0,3'd7,5'd31,8'd5);
    tbl[31] = mk(1'b1,2'd3,3'd0,5'd2, 1'b0,1'b0,1'b0, 1'b1,3'b000,1'b0,1'b1,1'b1,3'd7,5'd31,8'd5);
    tbl[32] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b100,1'b1,1'b0,1'b0,3'd7,5'd2, 8'd5);
    tbl[33] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b110,1'b1,1'b0,1'b0,3'd0,5'd2, 8'd5);
    tbl[34] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,3'b101,1'b1,1'b0,1'b0,3'd0,5'd2, 8'd5);
    tbl[35] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b1,3'b000,1'b0,1'b1,1'b0,3'd0,5'd2, 8'd6);
    tbl[36] = mk(1'b0,2'd0,3'd0,5'd0, 1'b0,1'b0,1'b0, 1'b1,3'b000,1'b0,1'b0,1'b0,3'd0,5'd2, 8'd6);

    reset = 1'b0; instr_valid = 1'b0; instr = '0; flush = 1'b0; flag_c = 1'b0; flag_ze = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", {9'd0, act()}, 32'd0);
    reset = 1'b1;

    // per-cycle table: drive, settle, compare, then let the next rising edge happen
    for (int i = 0; i < NV; i++) begin
      instr_valid = tbl[i].valid;
      instr       = tbl[i].instr;
      flush       = tbl[i].flush;
      flag_c      = tbl[i].c;
      flag_ze     = tbl[i].ze;
      #1;
      check($sformatf("row%0d", i), {9'd0, act()}, {9'd0, tbl[i].exp});
      @(negedge clk);
    end

    // async reset in the middle of an instruction
    instr_valid = 1'b1; instr = {2'd0, 3'd3, 5'd4}; flush = 1'b0; flag_c = 1'b0; flag_ze = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #1 check("pre_reset_busy", {31'd0, enableDB & enableR}, 32'd1);
    #1 reset = 1'b0;
    #1 check("async_reset_outputs", {9'd0, act()}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("ready_low_after_release", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    #1 check("ready_first_edge", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      if (done) begin
        seen = 1'b1;
        check("fresh_after_reset", {16'd0, F, B, retire_cnt}, {16'd0, 3'd3, 5'd4, 8'd1});
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) check("fresh_after_reset_timeout", 32'd0, 32'd1);

    // 256 back-to-back unconditional instructions: counter wrap and 4-cycle cadence
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    instr_valid = 1'b1; instr = {2'd0, 3'd1, 5'd1};
    ndone = 0; last_done = 0;
    for (cyc = 0; cyc < 1200 && ndone < 256; cyc++) begin
      #1;
      if (done) begin
        ndone++;
        if (ndone > 1) check($sformatf("cadence%0d", ndone), cyc - last_done, 4);
        last_done = cyc;
        if (ndone == 255) check("cnt_255", {24'd0, retire_cnt}, 32'd255);
        if (ndone == 256) begin
          check("cnt_wrap", {24'd0, retire_cnt}, 32'd0);
          instr_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("wrap_done_count", ndone, 256);
    instr_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
